stream_packet_arbiter: RTL and testbench

//  Shares one stream_upsize instance between N_SRC narrow packet sources.

---
 rtl/stream_packet_arbiter.sv | 127 ++++++++++++
 tb/tb_stream_packet_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_arbiter.sv
// ============================================================================
// Module   : stream_packet_arbiter
// Purpose  : Packet-granular round-robin arbiter that shares one narrow stream
//            sink (stream_upsize) between N_SRC sources, with a registered output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_packet_arbiter #(
  parameter int T_DATA_WIDTH = 4,
  parameter int N_SRC        = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_SRC*T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [N_SRC-1:0]                s_last_i,
  input  logic [N_SRC-1:0]                s_valid_i,
  output logic [N_SRC-1:0]                s_ready_o,
  output logic [T_DATA_WIDTH-1:0]         m_data_o,
  output logic                            m_last_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [((N_SRC == 1) ? 1 : $clog2(N_SRC))-1:0] m_src_o,
  output logic                            busy_o
);

  localparam int SRC_W = (N_SRC == 1) ? 1 : $clog2(N_SRC);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SRC_W-1:0]        r_grant;
  logic [SRC_W-1:0]        w_grant_nxt;
  logic [SRC_W-1:0]        r_rr_ptr;
  logic [SRC_W-1:0]        w_rr_ptr_nxt;
  logic [SRC_W-1:0]        w_pick;
  logic [2*N_SRC-1:0]      w_rot;
  int                      w_off;
  int                      w_sum;
  int                      w_inc;
  logic                    w_out_rdy;
  logic                    w_src_hs;
  logic                    w_src_last;
  logic [T_DATA_WIDTH-1:0] w_src_data;

  assign w_out_rdy  = !m_valid_o || m_ready_i;
  assign w_src_data = s_data_i[r_grant*T_DATA_WIDTH +: T_DATA_WIDTH];
  assign w_src_last = s_last_i[r_grant];
  assign w_src_hs   = (r_state == ST_LOCKED) && s_valid_i[r_grant] && w_out_rdy;
  assign busy_o     = (r_state == ST_LOCKED);

  // Rotate requests so bit 0 is the rr_ptr position; the lowest set bit wins.
  always_comb begin
    w_rot = {s_valid_i, s_valid_i} >> r_rr_ptr;
    w_off = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = k;
    end
    w_sum = int'(r_rr_ptr) + w_off;
    if (w_sum >= N_SRC) w_sum = w_sum - N_SRC;
    w_pick = SRC_W'(w_sum);
  end

  always_comb begin
    s_ready_o = '0;
    if (r_state == ST_LOCKED) s_ready_o[r_grant] = w_out_rdy;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_inc        = int'(r_grant) + 1;
    if (w_inc >= N_SRC) w_inc = 0;
    case (r_state)
      ST_IDLE: begin
        if (|s_valid_i) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_src_hs && w_src_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = SRC_W'(w_inc);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Single-entry output register; load and drain may coincide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
      m_src_o   <= '0;
    end else if (w_src_hs) begin
      m_valid_o <= 1'b1;
      m_data_o  <= w_src_data;
      m_last_o  <= w_src_last;
      m_src_o   <= r_grant;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_packet_arbiter.sv
// ============================================================================
// Module   : tb_stream_packet_arbiter
// Purpose  : Directed vector table plus packet sequences for stream_packet_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stream_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic [3:0]  s_last;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [3:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_src;
  logic        busy;

  stream_packet_arbiter #(.T_DATA_WIDTH(4), .N_SRC(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_data_i (s_data),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_src_o  (m_src),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] data;
    logic        mrdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [3:0]  exp_data;
    logic        exp_last;
    logic [1:0]  exp_src;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [0:11];

  // Per-source beat stores ({last, data}) and output capture
  logic [4:0] beats [0:3][0:31];
  int         wr [0:3];
  int         rd [0:3];
  int         hold_at [0:3];
  int         hold_len [0:3];
  int         hold_cnt [0:3];
  logic [3:0] hs_pend;
  logic       bp_en;
  logic       lock_chk;
  logic [3:0] o_data [0:63];
  logic       o_last [0:63];
  logic [1:0] o_src  [0:63];
  int         o_cyc  [0:63];
  int         out_n;
  int         cyc;
  logic       prev_stall;
  logic [3:0] prev_data;
  logic       prev_last;
  logic [1:0] prev_src;

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0; rd[i] = 0; hold_at[i] = -1; hold_len[i] = 0; hold_cnt[i] = 0;
    end
    hs_pend = '0; out_n = 0; cyc = 0; prev_stall = 1'b0; lock_chk = 1'b0; bp_en = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
    clear_sources();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int s, input logic last, input logic [3:0] d);
    beats[s][wr[s]] = {last, d};
    wr[s]++;
  endtask

  task automatic step();
    logic masked;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) if (hs_pend[i]) rd[i]++;
    for (int i = 0; i < 4; i++) begin
      masked = (rd[i] == hold_at[i]) && (hold_cnt[i] < hold_len[i]);
      if (masked) hold_cnt[i]++;
      s_valid[i]       = (rd[i] < wr[i]) && !masked;
      s_data[i*4 +: 4] = beats[i][rd[i]][3:0];
      s_last[i]        = beats[i][rd[i]][4];
    end
    m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    hs_pend = s_valid & s_ready;
    chk("ready_onehot0", 32'($onehot0(s_ready)), 1);
    if (lock_chk && rd[0] < 4) chk("lock_ready1", 32'(s_ready[1]), 0);
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_last", 32'(m_last), 32'(prev_last));
      chk("stall_src", 32'(m_src), 32'(prev_src));
    end
    if (m_valid && m_ready && out_n < 64) begin
      o_data[out_n] = m_data; o_last[out_n] = m_last; o_src[out_n] = m_src;
      o_cyc[out_n] = cyc; out_n++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data = m_data; prev_last = m_last; prev_src = m_src;
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int b;
    b = 0;
    while (out_n < n && b < budget) begin
      step();
      b++;
    end
    chk(name, out_n, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid last data mrdy | ready valid data last src busy
    vecs[0]  = '{4'b0100, 4'b0000, 16'h0100, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0000, 16'h0100, 1'b1, 4'b0100, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0000, 16'h0200, 1'b1, 4'b0100, 1'b1, 4'h1, 1'b0, 2'd2, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0100, 16'h0300, 1'b1, 4'b0100, 1'b1, 4'h2, 1'b0, 2'd2, 1'b1};
    vecs[4]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'h3, 1'b1, 2'd2, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{4'b1010, 4'b1010, 16'h9050, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{4'b1010, 4'b1010, 16'h9050, 1'b1, 4'b1000, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{4'b0010, 4'b0010, 16'h0050, 1'b1, 4'b0000, 1'b1, 4'h9, 1'b1, 2'd3, 1'b0};
    vecs[9]  = '{4'b0010, 4'b0010, 16'h0050, 1'b1, 4'b0010, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1};
    vecs[10] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'h5, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};

    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
    clear_sources();
    repeat (2) @(negedge clk);

    // Reset asserted in the middle of a src0 packet
    rst = 1'b0; s_valid = 4'b0001; s_data = 16'h0006; s_last = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(m_valid), 1);
    chk("pre_rst_data", 32'(m_data), 6);
    chk("pre_rst_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_src", 32'(m_src), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("rst_hold_busy", 32'(busy), 0);
    chk("rst_hold_ready", 32'(s_ready), 0);
    @(negedge clk);
    rst = 1'b0; s_valid = '0; s_data = '0;

    // Vector table: src2 3-beat packet, then wrap from rr_ptr=3 (src3 before src1)
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s_valid = vecs[i].valid; s_last = vecs[i].last;
      s_data = vecs[i].data; m_ready = vecs[i].mrdy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
        chk($sformatf("v%0d_last", i), 32'(m_last), 32'(vecs[i].exp_last));
        chk($sformatf("v%0d_src", i), 32'(m_src), 32'(vecs[i].exp_src));
      end
    end

    // Fairness: two rounds of 2-beat packets from every source
    reset_dut();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++)
        for (int b = 0; b < 2; b++) push(s, b == 1, 4'(s * 4 + p * 2 + b));
    run_until("fair_count", 16, 200);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fair_src%0d", k), 32'(o_src[k]), (k / 2) % 4);
      chk($sformatf("fair_data%0d", k), 32'(o_data[k]), ((k / 2) % 4) * 4 + (k / 8) * 2 + (k % 2));
      chk($sformatf("fair_last%0d", k), 32'(o_last[k]), k % 2);
    end
    for (int q = 1; q < 8; q++) chk($sformatf("fair_gap%0d", q), o_cyc[2*q] - o_cyc[2*q-2], 3);

    // Packet lock: src0 stalls for 3 cycles mid-packet while src1 requests
    reset_dut();
    push(0, 1'b0, 4'h1); push(0, 1'b0, 4'h2); push(0, 1'b0, 4'h3); push(0, 1'b1, 4'h4);
    push(1, 1'b0, 4'h7); push(1, 1'b1, 4'h8);
    hold_at[0] = 2; hold_len[0] = 3; lock_chk = 1'b1;
    run_until("lock_count", 6, 100);
    lock_chk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("lock_data%0d", k), 32'(o_data[k]), (k < 4) ? k + 1 : k + 3);
      chk($sformatf("lock_src%0d", k), 32'(o_src[k]), (k < 4) ? 0 : 1);
    end

    // Backpressure: random m_ready on a 5-beat packet A..E
    reset_dut();
    for (int b = 0; b < 5; b++) push(0, b == 4, 4'(10 + b));
    bp_en = 1'b1;
    run_until("bp_count", 5, 200);
    bp_en = 1'b0;
    repeat (5) step();
    chk("bp_no_dup", out_n, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_data%0d", k), 32'(o_data[k]), 10 + k);
      chk($sformatf("bp_last%0d", k), 32'(o_last[k]), (k == 4) ? 1 : 0);
    end

    // Throughput: 8-beat packet with m_ready held high
    reset_dut();
    for (int b = 0; b < 8; b++) push(1, b == 7, 4'(b));
    run_until("tp_count", 8, 100);
    for (int k = 1; k < 8; k++) chk($sformatf("tp_cyc%0d", k), o_cyc[k] - o_cyc[0], k);
    for (int k = 0; k < 8; k++) chk($sformatf("tp_data%0d", k), 32'(o_data[k]), k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
